// File: rtl/fft4_input_buffer_if.sv
// Stream bundle for the FFT4 input buffer: serial complex samples in,
// one parallel 4-sample frame out.
interface fft4_input_buffer_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               in_sof;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] x0r;
    logic signed [15:0] x0i;
    logic signed [15:0] x1r;
    logic signed [15:0] x1i;
    logic signed [15:0] x2r;
    logic signed [15:0] x2i;
    logic signed [15:0] x3r;
    logic signed [15:0] x3i;
    logic               sync_err;

    modport master (
        output in_valid, in_re, in_im, in_sof, out_ready,
        input  in_ready, out_valid, sync_err,
        input  x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i
    );

    modport slave (
        input  in_valid, in_re, in_im, in_sof, out_ready,
        output in_ready, out_valid, sync_err,
        output x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i
    );
endinterface

// File: rtl/fft4_input_buffer.sv
// Serial-to-parallel frame buffer feeding a 4-point FFT.
// Define FFT4_PRESCALE_EN to arithmetic-shift each stored component right by 2.
module fft4_input_buffer (
    input logic                  clk,
    input logic                  rst,
    fft4_input_buffer_if.slave   bus
);
    logic        [1:0]  r_cnt;
    logic               r_fill_full;
    logic               r_out_valid;
    logic               r_sync_err;
    logic signed [15:0] r_buf_re [4];
    logic signed [15:0] r_buf_im [4];
    logic signed [15:0] r_x_re   [4];
    logic signed [15:0] r_x_im   [4];

    logic               w_accept;
    logic               w_out_free;
    logic               w_resync;
    logic               w_last;
    logic               w_load_direct;
    logic               w_load_buf;
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;

`ifdef FFT4_PRESCALE_EN
    assign w_re = bus.in_re >>> 2;
    assign w_im = bus.in_im >>> 2;
`else
    assign w_re = bus.in_re;
    assign w_im = bus.in_im;
`endif

    assign w_accept      = bus.in_valid && !r_fill_full;
    assign w_out_free    = !r_out_valid || bus.out_ready;
    assign w_resync      = bus.in_sof && (r_cnt != 2'd0);
    assign w_last        = w_accept && !w_resync && (r_cnt == 2'd3);
    assign w_load_direct = w_last && w_out_free;
    assign w_load_buf    = r_fill_full && w_out_free;

    // Sample buffer carries no reset; stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_resync) begin
                r_buf_re[0] <= w_re;
                r_buf_im[0] <= w_im;
            end else begin
                r_buf_re[r_cnt] <= w_re;
                r_buf_im[r_cnt] <= w_im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 2'd0;
            r_fill_full <= 1'b0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_x_re[i] <= '0;
                r_x_im[i] <= '0;
            end
        end else begin
            r_sync_err <= w_accept && w_resync;

            if (w_accept) begin
                if (w_resync) begin
                    r_cnt <= 2'd1;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end

            if (w_last && !w_out_free) begin
                r_fill_full <= 1'b1;
            end else if (w_load_buf) begin
                r_fill_full <= 1'b0;
            end

            // Last sample bypasses the buffer so a frame needs no extra cycle.
            if (w_load_direct) begin
                for (int i = 0; i < 3; i++) begin
                    r_x_re[i] <= r_buf_re[i];
                    r_x_im[i] <= r_buf_im[i];
                end
                r_x_re[3]   <= w_re;
                r_x_im[3]   <= w_im;
                r_out_valid <= 1'b1;
            end else if (w_load_buf) begin
                for (int i = 0; i < 4; i++) begin
                    r_x_re[i] <= r_buf_re[i];
                    r_x_im[i] <= r_buf_im[i];
                end
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !r_fill_full;
    assign bus.out_valid = r_out_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.x0r       = r_x_re[0];
    assign bus.x0i       = r_x_im[0];
    assign bus.x1r       = r_x_re[1];
    assign bus.x1i       = r_x_im[1];
    assign bus.x2r       = r_x_re[2];
    assign bus.x2i       = r_x_im[2];
    assign bus.x3r       = r_x_re[3];
    assign bus.x3i       = r_x_im[3];
endmodule

// File: tb/tb_fft4_input_buffer.sv
// Scoreboard bench for fft4_input_buffer: directed scenarios plus a long
// random valid/ready run; a monitor pops expected frames on each handshake.
module tb_fft4_input_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fft4_input_buffer_if b ();

    fft4_input_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_sync = 0;
    int obs_sync = 0;
    bit done = 1'b0;
    bit rmode = 1'b0;

    logic [127:0]       exp_q [$];
    int                 mcnt = 0;
    logic signed [15:0] mre [4];
    logic signed [15:0] mim [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] scale(input logic signed [15:0] v);
`ifdef FFT4_PRESCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    function automatic logic [127:0] cur_frame();
        return {b.x0r, b.x0i, b.x1r, b.x1i, b.x2r, b.x2i, b.x3r, b.x3i};
    endfunction

    task automatic model_accept(input logic signed [15:0] re,
                                input logic signed [15:0] im,
                                input bit sof);
        if (sof && mcnt != 0) begin
            mcnt = 0;
            exp_sync++;
        end
        mre[mcnt] = scale(re);
        mim[mcnt] = scale(im);
        mcnt++;
        if (mcnt == 4) begin
            exp_q.push_back({mre[0], mim[0], mre[1], mim[1],
                             mre[2], mim[2], mre[3], mim[3]});
            mcnt = 0;
        end
    endtask

    task automatic send(input int re, input int im, input bit sof);
        int n = 0;
        b.in_valid = 1'b1;
        b.in_re    = re[15:0];
        b.in_im    = im[15:0];
        b.in_sof   = sof;
        @(negedge clk);
        while (!b.in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!b.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 expected 1");
            b.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(re[15:0], im[15:0], sof);
        #1;
        b.in_valid = 1'b0;
        b.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Monitor: handshake pops, stall stability, sync_err pulse count.
    logic [127:0] held;
    bit           stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (cur_frame() !== held) begin
                    errors++;
                    $display("FAIL hold: got %h expected %h", cur_frame(), held);
                end
            end
            if (b.out_valid && b.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame: got %h expected none", cur_frame());
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (cur_frame() !== e) begin
                        errors++;
                        $display("FAIL frame: got %h expected %h", cur_frame(), e);
                    end
                end
            end
            stalled = b.out_valid && !b.out_ready;
            held    = cur_frame();
            if (b.sync_err) obs_sync++;
        end
    end

    initial begin
        while (!done) begin
            @(posedge clk);
            #1;
            if (rmode) b.out_ready = ($urandom % 3) != 0;
        end
    end

    initial begin
        b.in_valid  = 1'b0;
        b.in_re     = '0;
        b.in_im     = '0;
        b.in_sof    = 1'b0;
        b.out_ready = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(b.in_ready), 1);
        chk("rst_out_valid", int'(b.out_valid), 0);
        chk("rst_sync_err", int'(b.sync_err), 0);
        chk("rst_x0r", int'(b.x0r), 0);
        chk("rst_x3i", int'(b.x3i), 0);
        @(posedge clk);
        #1;

        // Four back-to-back samples, ready held high.
        b.out_ready = 1'b1;
        send(1, 0, 1'b1);
        send(2, 0, 1'b0);
        send(3, 0, 1'b0);
        send(4, 0, 1'b0);
        chk("basic_out_valid", int'(b.out_valid), 1);
`ifdef FFT4_PRESCALE_EN
        chk("basic_x0r", int'(b.x0r), 0);
        chk("basic_x1r", int'(b.x1r), 0);
        chk("basic_x2r", int'(b.x2r), 0);
        chk("basic_x3r", int'(b.x3r), 1);
`else
        chk("basic_x0r", int'(b.x0r), 1);
        chk("basic_x1r", int'(b.x1r), 2);
        chk("basic_x2r", int'(b.x2r), 3);
        chk("basic_x3r", int'(b.x3r), 4);
`endif
        chk("basic_x2i", int'(b.x2i), 0);
        drain();

        // Backpressure: eight samples with downstream stalled.
        b.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(i, 0, 1'b0);
        chk("bp_in_ready_low", int'(b.in_ready), 0);
        chk("bp_out_valid", int'(b.out_valid), 1);
`ifdef FFT4_PRESCALE_EN
        chk("bp_x3r_held", int'(b.x3r), 1);
`else
        chk("bp_x3r_held", int'(b.x3r), 4);
`endif
        idle(3);
        b.out_ready = 1'b1;
        drain();
        chk("bp_in_ready_back", int'(b.in_ready), 1);

        // Mid-frame start-of-frame resynchronises.
        send(11, 0, 1'b0);
        send(12, 0, 1'b0);
        send(9, -9, 1'b1);
        chk("sof_pulse", int'(b.sync_err), 1);
        idle(1);
        chk("sof_pulse_end", int'(b.sync_err), 0);
        send(10, -10, 1'b0);
        send(11, -11, 1'b0);
        send(12, -12, 1'b0);
`ifdef FFT4_PRESCALE_EN
        chk("sof_x0r", int'(b.x0r), 2);
        chk("sof_x0i", int'(b.x0i), -3);
`else
        chk("sof_x0r", int'(b.x0r), 9);
        chk("sof_x0i", int'(b.x0i), -9);
`endif
        drain();

        // Reset mid-frame discards the partial frame.
        send(21, 0, 1'b0);
        send(22, 0, 1'b0);
        send(23, 0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        mcnt = 0;
        chk("midrst_out_valid", int'(b.out_valid), 0);
        chk("midrst_in_ready", int'(b.in_ready), 1);
        send(31, 1, 1'b0);
        send(32, 2, 1'b0);
        send(33, 3, 1'b0);
        send(34, 4, 1'b0);
`ifdef FFT4_PRESCALE_EN
        chk("midrst_x0r", int'(b.x0r), 7);
`else
        chk("midrst_x0r", int'(b.x0r), 31);
`endif
        drain();

        // Prescale behaviour on a negative component.
        send(-5, 7, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
`ifdef FFT4_PRESCALE_EN
        chk("scale_x0r", int'(b.x0r), -2);
        chk("scale_x0i", int'(b.x0i), 1);
`else
        chk("scale_x0r", int'(b.x0r), -5);
        chk("scale_x0i", int'(b.x0i), 7);
`endif
        drain();

        // Random valid/ready over many frames.
        rmode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < 4; i++) begin
                bit s;
                if ($urandom % 3 == 0) idle(1 + $urandom % 2);
                s = (i == 0) ? bit'($urandom % 2) : ($urandom % 40 == 0);
                send(int'($urandom), int'($urandom), s);
            end
        end
        rmode = 1'b0;
        b.out_ready = 1'b1;
        idle(1);
        drain();
        idle(2);
        chk("sync_err_count", obs_sync, exp_sync);
        chk("final_in_ready", int'(b.in_ready), 1);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
